// File: rtl/fu_branch_resolver.sv
// Branch resolution unit: queues fetch-time predictions, resolves branches in order at execute,
// and drives BTB updates plus a fetch redirect on mispredict.
module fu_branch_resolver #(
  parameter int WORD_W      = 32,
  parameter int QUEUE_DEPTH = 8,
  parameter int QPTR_W      = 3
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              pred_push,
  input  logic [WORD_W-1:0] pred_pc,
  input  logic              pred_taken,
  input  logic [WORD_W-1:0] pred_target,
  output logic              pred_ready,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [WORD_W-1:0] res_rs1,
  input  logic [WORD_W-1:0] res_rs2,
  input  logic [2:0]        res_funct3,
  input  logic [WORD_W-1:0] res_imm,
  output logic              update_btb,
  output logic [WORD_W-1:0] update_pc,
  output logic              branch_outcome,
  output logic [WORD_W-1:0] branch_target,
  output logic              mispredict,
  output logic [WORD_W-1:0] correct_pc,
  output logic [QPTR_W:0]   inflight_cnt
);

  logic [WORD_W-1:0]      q_pc     [QUEUE_DEPTH];
  logic [WORD_W-1:0]      q_target [QUEUE_DEPTH];
  logic [QUEUE_DEPTH-1:0] q_taken;

  logic [QPTR_W-1:0] rd_ptr, wr_ptr;
  logic [QPTR_W:0]   cnt;

  logic              full, pop_ok, push_ok, push_wr;
  logic              actual, mis;
  logic              head_taken;
  logic [WORD_W-1:0] head_pc, head_target, target, fallthrough;

  assign full       = (cnt == (QPTR_W+1)'(QUEUE_DEPTH));
  assign pred_ready = ~full;
  assign res_ready  = (cnt != '0);
  assign inflight_cnt = cnt;

  assign pop_ok  = res_valid & res_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = pred_push & (~full | pop_ok);
  // Pushes in a mispredicting resolve cycle are wrong-path and never land.
  assign push_wr = push_ok & ~(pop_ok & mis);

  assign head_pc     = q_pc[rd_ptr];
  assign head_target = q_target[rd_ptr];
  assign head_taken  = q_taken[rd_ptr];
  assign target      = head_pc + res_imm;
  assign fallthrough = head_pc + WORD_W'(4);

  always_comb begin
    actual = 1'b0;
    case (res_funct3)
      3'b000:  actual = (res_rs1 == res_rs2);
      3'b001:  actual = (res_rs1 != res_rs2);
      3'b100:  actual = ($signed(res_rs1) <  $signed(res_rs2));
      3'b101:  actual = ($signed(res_rs1) >= $signed(res_rs2));
      3'b110:  actual = (res_rs1 <  res_rs2);
      3'b111:  actual = (res_rs1 >= res_rs2);
      default: actual = 1'b0;
    endcase
  end

  assign mis = (actual != head_taken) | (actual & head_taken & (head_target != target));

  always_ff @(posedge CLK) begin
    if (push_wr) begin
      q_pc[wr_ptr]     <= pred_pc;
      q_target[wr_ptr] <= pred_target;
      q_taken[wr_ptr]  <= pred_taken;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else if (pop_ok && mis) begin
      rd_ptr <= rd_ptr + 1'b1;
      wr_ptr <= rd_ptr + 1'b1;
      cnt    <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop_ok)      cnt <= cnt + 1'b1;
      else if (!push_ok && pop_ok) cnt <= cnt - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      update_btb     <= 1'b0;
      mispredict     <= 1'b0;
      update_pc      <= '0;
      branch_outcome <= 1'b0;
      branch_target  <= '0;
      correct_pc     <= '0;
    end else begin
      update_btb <= pop_ok;
      mispredict <= pop_ok & mis;
      if (pop_ok) begin
        update_pc      <= head_pc;
        branch_outcome <= actual;
        branch_target  <= target;
        correct_pc     <= actual ? target : fallthrough;
      end
    end
  end

endmodule

// File: tb/tb_fu_branch_resolver.sv
// Scoreboard bench for fu_branch_resolver: directed pushes/resolves queue expected BTB updates,
// a negedge monitor pops and compares each strobe.
module tb_fu_branch_resolver;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        pred_push = 1'b0;
  logic [31:0] pred_pc = '0;
  logic        pred_taken = 1'b0;
  logic [31:0] pred_target = '0;
  logic        pred_ready;
  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [31:0] res_rs1 = '0, res_rs2 = '0, res_imm = '0;
  logic [2:0]  res_funct3 = '0;
  logic        update_btb;
  logic [31:0] update_pc;
  logic        branch_outcome;
  logic [31:0] branch_target;
  logic        mispredict;
  logic [31:0] correct_pc;
  logic [3:0]  inflight_cnt;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [31:0] pc;
    logic        outcome;
    logic [31:0] tgt;
    logic        mis;
    logic [31:0] cpc;
  } exp_t;

  exp_t exp_q[$];

  fu_branch_resolver dut (
    .CLK(CLK), .nRST(nRST),
    .pred_push(pred_push), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_ready(pred_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_rs1(res_rs1), .res_rs2(res_rs2), .res_funct3(res_funct3), .res_imm(res_imm),
    .update_btb(update_btb), .update_pc(update_pc), .branch_outcome(branch_outcome),
    .branch_target(branch_target), .mispredict(mispredict), .correct_pc(correct_pc),
    .inflight_cnt(inflight_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got=%h want=%h t=%0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (nRST) begin
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        chk("update_btb", 32'(update_btb), 32'd1);
        chk("update_pc", update_pc, e.pc);
        chk("branch_outcome", 32'(branch_outcome), 32'(e.outcome));
        chk("branch_target", branch_target, e.tgt);
        chk("mispredict", 32'(mispredict), 32'(e.mis));
        if (e.mis) chk("correct_pc", correct_pc, e.cpc);
      end else if (update_btb || mispredict) begin
        chk("spurious_strobe", {30'd0, update_btb, mispredict}, 32'd0);
      end
    end
  end

  // One clock of stimulus; the expectation is queued only once the handshake edge has passed.
  task automatic step(input bit push, input logic [31:0] ppc, input bit ptk, input logic [31:0] ptg,
                      input bit res, input logic [2:0] f3, input logic [31:0] rs1,
                      input logic [31:0] rs2, input logic [31:0] imm, input exp_t e);
    pred_push = push; pred_pc = ppc; pred_taken = ptk; pred_target = ptg;
    res_valid = res; res_funct3 = f3; res_rs1 = rs1; res_rs2 = rs2; res_imm = imm;
    @(posedge CLK);
    if (res) exp_q.push_back(e);
    #1;
    pred_push = 1'b0;
    res_valid = 1'b0;
  endtask

  task automatic push_only(input logic [31:0] ppc, input bit ptk, input logic [31:0] ptg);
    exp_t none;
    none = '{32'd0, 1'b0, 32'd0, 1'b0, 32'd0};
    step(1'b1, ppc, ptk, ptg, 1'b0, 3'b000, 32'd0, 32'd0, 32'd0, none);
  endtask

  task automatic res_only(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input exp_t e);
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, f3, rs1, rs2, imm, e);
  endtask

  initial begin
    exp_t none;
    none = '{32'd0, 1'b0, 32'd0, 1'b0, 32'd0};
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_pred_ready", 32'(pred_ready), 32'd1);
    chk("rst_res_ready", 32'(res_ready), 32'd0);
    chk("rst_update_btb", 32'(update_btb), 32'd0);
    chk("rst_mispredict", 32'(mispredict), 32'd0);
    chk("rst_cnt", 32'(inflight_cnt), 32'd0);
    nRST = 1'b1;
    @(posedge CLK); #1;

    // BEQ taken, predicted NT
    push_only(32'h100, 1'b0, 32'h0);
    chk("cnt_after_push", 32'(inflight_cnt), 32'd1);
    res_only(3'b000, 32'd5, 32'd5, 32'hFFFF_FFF0, '{32'h100, 1'b1, 32'hF0, 1'b1, 32'hF0});
    chk("cnt_after_mis", 32'(inflight_cnt), 32'd0);

    // BNE correctly predicted taken
    push_only(32'h200, 1'b1, 32'h1F0);
    res_only(3'b001, 32'd1, 32'd2, 32'hFFFF_FFF0, '{32'h200, 1'b1, 32'h1F0, 1'b0, 32'h1F0});
    // BLTU 0xFFFFFFFF < 1 is false, predicted NT
    push_only(32'h240, 1'b0, 32'h0);
    res_only(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h10, '{32'h240, 1'b0, 32'h250, 1'b0, 32'h244});
    // BLT signed -1 < 1 taken, wrong predicted target
    push_only(32'h300, 1'b1, 32'h400);
    res_only(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h20, '{32'h300, 1'b1, 32'h320, 1'b1, 32'h320});
    // funct3 010 never taken; predicted T -> redirect to fallthrough
    push_only(32'h500, 1'b1, 32'h520);
    res_only(3'b010, 32'd7, 32'd7, 32'h20, '{32'h500, 1'b0, 32'h520, 1'b1, 32'h504});
    // BGE 5>=5 taken, correct
    push_only(32'h600, 1'b1, 32'h610);
    res_only(3'b101, 32'd5, 32'd5, 32'h10, '{32'h600, 1'b1, 32'h610, 1'b0, 32'h610});
    // BGEU 1 >= 0xFFFFFFFF false, predicted NT
    push_only(32'h700, 1'b0, 32'h0);
    res_only(3'b111, 32'd1, 32'hFFFF_FFFF, 32'h8, '{32'h700, 1'b0, 32'h708, 1'b0, 32'h704});

    // Resolve on empty queue: no expectation queued, monitor flags any strobe
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 3'b000, 32'd1, 32'd1, 32'd4, none);
    exp_q.delete();
    chk("cnt_empty_res", 32'(inflight_cnt), 32'd0);
    @(posedge CLK); #1;

    // Fill to full, overflow push ignored
    for (int i = 0; i < 8; i++) push_only(32'h800 + 32'(4*i), 1'b1, 32'h840 + 32'(4*i));
    chk("full_pred_ready", 32'(pred_ready), 32'd0);
    chk("full_cnt", 32'(inflight_cnt), 32'd8);
    push_only(32'h900, 1'b0, 32'h0);
    chk("overflow_cnt", 32'(inflight_cnt), 32'd8);
    res_only(3'b000, 32'd1, 32'd1, 32'h40, '{32'h800, 1'b1, 32'h840, 1'b0, 32'h840});
    chk("cnt_after_pop", 32'(inflight_cnt), 32'd7);
    // Mispredict with concurrent push: flush and drop
    step(1'b1, 32'hA00, 1'b1, 32'hA10, 1'b1, 3'b000, 32'd1, 32'd2, 32'h40,
         '{32'h804, 1'b0, 32'h844, 1'b1, 32'h808});
    chk("flush_cnt", 32'(inflight_cnt), 32'd0);
    chk("flush_res_ready", 32'(res_ready), 32'd0);
    push_only(32'hB00, 1'b1, 32'hB10);
    res_only(3'b000, 32'd1, 32'd1, 32'h10, '{32'hB00, 1'b1, 32'hB10, 1'b0, 32'hB10});

    // Pointer wrap with push+pop at full
    for (int i = 0; i < 8; i++) push_only(32'h1000 + 32'(16*i), 1'b1, 32'h1008 + 32'(16*i));
    for (int k = 0; k < 20; k++) begin
      step(1'b1, 32'h1000 + 32'(16*(k+8)), 1'b1, 32'h1008 + 32'(16*(k+8)),
           1'b1, 3'b000, 32'd3, 32'd3, 32'h8,
           '{32'h1000 + 32'(16*k), 1'b1, 32'h1008 + 32'(16*k), 1'b0, 32'h1008 + 32'(16*k)});
      chk("wrap_cnt", 32'(inflight_cnt), 32'd8);
    end
    for (int k = 20; k < 28; k++)
      res_only(3'b000, 32'd3, 32'd3, 32'h8,
               '{32'h1000 + 32'(16*k), 1'b1, 32'h1008 + 32'(16*k), 1'b0, 32'h1008 + 32'(16*k)});
    chk("drain_cnt", 32'(inflight_cnt), 32'd0);

    // Reset during a resolve cycle
    for (int i = 0; i < 3; i++) push_only(32'h2000 + 32'(4*i), 1'b0, 32'h0);
    chk("pre_rst_cnt", 32'(inflight_cnt), 32'd3);
    res_valid = 1'b1; res_funct3 = 3'b000; res_rs1 = 32'd1; res_rs2 = 32'd1; res_imm = 32'h10;
    #2 nRST = 1'b0;
    @(posedge CLK); #1;
    chk("midrst_update_btb", 32'(update_btb), 32'd0);
    chk("midrst_mispredict", 32'(mispredict), 32'd0);
    chk("midrst_cnt", 32'(inflight_cnt), 32'd0);
    chk("midrst_res_ready", 32'(res_ready), 32'd0);
    res_valid = 1'b0;
    #2 nRST = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_update_btb", 32'(update_btb), 32'd0);

    repeat (2) @(posedge CLK);
    chk("missing_strobes", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got=running want=finished");
    $fatal(1);
  end

endmodule
